// File: rtl/mips_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_exec_unit
// Description : Registered MIPS16 execute stage with valid/ready handshake and
//               an iterative shift-add multiplier. Owns the architectural PC.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_exec_unit #(
    parameter int DATA_W = 16,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [3:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] jtarget,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] pc_out,
    output logic              illegal
);

    localparam logic [2:0]        c_op_rtype = 3'b000;
    localparam logic [2:0]        c_op_slti  = 3'b001;
    localparam logic [2:0]        c_op_j     = 3'b010;
    localparam logic [2:0]        c_op_jal   = 3'b011;
    localparam logic [2:0]        c_op_beq   = 3'b110;
    localparam logic [2:0]        c_op_addi  = 3'b111;

    localparam logic [3:0]        c_fn_add   = 4'd0;
    localparam logic [3:0]        c_fn_sub   = 4'd1;
    localparam logic [3:0]        c_fn_and   = 4'd2;
    localparam logic [3:0]        c_fn_or    = 4'd3;
    localparam logic [3:0]        c_fn_xor   = 4'd4;
    localparam logic [3:0]        c_fn_sll   = 4'd5;
    localparam logic [3:0]        c_fn_srl   = 4'd6;
    localparam logic [3:0]        c_fn_slt   = 4'd7;
    localparam logic [3:0]        c_fn_mul   = 4'd8;

    localparam logic [DATA_W-1:0] c_one      = DATA_W'(1);
    localparam logic [SH_W-1:0]   c_cnt_one  = SH_W'(1);
    localparam logic [SH_W-1:0]   c_cnt_last = SH_W'(DATA_W - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_pc;
    logic                r_illegal;

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_acc;
    logic [SH_W-1:0]     r_count;

    logic [DATA_W-1:0]   w_result;
    logic [DATA_W-1:0]   w_pc_inc;
    logic [DATA_W-1:0]   w_pc_next;
    logic                w_illegal;
    logic                w_is_mul;
    logic                w_out_free;
    logic                w_accept;
    logic                w_load_single;
    logic                w_mul_done;
    logic [DATA_W-1:0]   w_mul_sum;

    assign w_pc_inc      = r_pc + c_one;
    assign w_out_free    = !r_out_valid || out_ready;
    assign in_ready      = (r_state == S_IDLE) && w_out_free;
    assign w_accept      = in_valid && in_ready;
    assign w_load_single = w_accept && !w_is_mul;
    assign w_mul_done    = (r_state == S_MUL) && (r_count == '0) && w_out_free;
    assign w_mul_sum     = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Decode and single-cycle ALU; reserved encodings yield 0 with illegal set.
    always_comb begin
        w_result  = '0;
        w_pc_next = w_pc_inc;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (opcode)
            c_op_rtype: begin
                case (funct)
                    c_fn_add: w_result = rs_val + rt_val;
                    c_fn_sub: w_result = rs_val - rt_val;
                    c_fn_and: w_result = rs_val & rt_val;
                    c_fn_or:  w_result = rs_val | rt_val;
                    c_fn_xor: w_result = rs_val ^ rt_val;
                    c_fn_sll: w_result = rs_val << rt_val[SH_W-1:0];
                    c_fn_srl: w_result = rs_val >> rt_val[SH_W-1:0];
                    c_fn_slt: w_result = {{(DATA_W-1){1'b0}},
                                          ($signed(rs_val) < $signed(rt_val))};
                    c_fn_mul: w_is_mul = 1'b1;
                    default:  w_illegal = 1'b1;
                endcase
            end
            c_op_slti: w_result = {{(DATA_W-1){1'b0}},
                                   ($signed(rs_val) < $signed(imm))};
            c_op_j:    w_pc_next = jtarget;
            c_op_jal: begin
                w_result  = w_pc_inc;
                w_pc_next = jtarget;
            end
            c_op_beq: begin
                w_result = rs_val - rt_val;
                if (rs_val == rt_val) begin
                    w_pc_next = imm;
                end
            end
            c_op_addi: w_result = rs_val + imm;
            default:   w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_next = S_MUL;
            S_MUL:  if (w_mul_done)           w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counter 0 holds off the final bit so completion can wait on a full
    // output register without double-adding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= rs_val;
            r_mplier <= rt_val;
            r_acc    <= '0;
            r_count  <= c_cnt_last;
        end else if ((r_state == S_MUL) && (r_count != '0)) begin
            r_acc    <= w_mul_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_pc        <= '0;
            r_illegal   <= 1'b0;
        end else if (w_load_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_pc        <= w_pc_next;
            r_illegal   <= w_illegal;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_mul_sum;
            r_pc        <= w_pc_inc;
            r_illegal   <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign pc_out     = r_pc;
    assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: doc/mips_exec_unit.md
# mips_exec_unit

Parametrised, registered execute stage for the MIPS16 datapath. It accepts one decoded instruction per valid/ready handshake and computes the ALU result and next PC. Results are held in an output register with backpressure. An iterative multiplier adds a multi-cycle mode. The block sits between decode/register-read and write-back, and owns the architectural PC.

## Interface
- DATA_W, 16, datapath and PC width (≥ 4, power of 2)
- SH_W, $clog2(DATA_W), shift-amount width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept this cycle
- opcode  in  3  major opcode
- funct  in  4  R-type function
- rs_val  in  DATA_W  first operand
- rt_val  in  DATA_W  second operand
- imm  in  DATA_W  sign-extended immediate / beq target
- jtarget  in  DATA_W  jump target
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer takes result
- alu_result  out  DATA_W  computed value / link address
- pc_out  out  DATA_W  PC after this instruction
- illegal  out  1  result came from a reserved encoding

## Operation
- Opcodes:
  - 000 R-type
  - 001 slti: result = (signed rs_val < signed imm)
  - 010 j: pc = jtarget, result 0
  - 011 jal: result = pc+1, pc = jtarget
  - 110 beq: pc = imm if rs_val==rt_val, else pc+1; result = rs_val−rt_val
  - 111 addi: rs_val+imm
  - 100/101: reserved
- funct codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 sll, 6 srl, by rt_val[SH_W-1:0]
  - 7 slt (signed)
  - 8 mul (multi-cycle)
  - 9–15: reserved
- Every non-jump, non-taken instruction: pc = pc+1. pc_out presents the updated PC with the result.
- All arithmetic is modulo 2^DATA_W. mul returns the low DATA_W bits of the unsigned product. PC wraps from all-ones to 0.
- Reserved encoding: result 0, illegal=1, PC still increments.
- FSM:
  - IDLE: on accept of mul → MUL, otherwise result loads directly.
  - MUL: shift-add, one multiplier bit per cycle, counter DATA_W−1 down to 0. At counter 0, load the result register → IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output register loads only when empty or drained the same cycle. Contents are stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=1 (after reset), out_valid=0, alu_result=0, pc_out=0, illegal=0, internal PC=0, state IDLE, counter 0.
- Single-cycle ops: accepted at edge N → out_valid=1 after edge N (visible in cycle N+1). Back-to-back throughput is 1/cycle when out_ready=1.
- mul: accepted at edge N → out_valid after edge N+DATA_W (latency DATA_W). in_ready=0 throughout.
- Simultaneous drain and accept: new result replaces old in the same edge. out_valid stays 1.
- out_valid && !out_ready: in_ready=0. Inputs are ignored and the PC does not change.
- mul finishing while the output is held: completion is deferred. FSM stays in MUL at counter 0 until the register empties.
- rst_n low on any edge (including mid-mul): abort and apply reset values. rst_n dominates all other inputs.
- Operands are sampled only at the accept edge. Changes afterwards do not affect an in-flight mul.

## Test plan
- After reset, add rs=2 rt=1 with out_ready=1 → next cycle alu_result=3, pc_out=1, out_valid=1, illegal=0.
- slti rs=0xFFFF imm=1 → 1; sub 1−2 → 0xFFFF; sll 1 by 15 → 0x8000; preset PC 0xFFFF, then addi → pc_out=0x0000.
- j jtarget=0x000A → pc_out=0x000A. beq rs=rt, imm=0x000F → pc_out=0x000F. beq rs≠rt → pc+1. jal from PC=5 → alu_result=6, pc_out=0x000A.
- mul 7×6 → in_ready low 16 cycles, alu_result=42. 0x0100×0x0100 → 0 (truncation). out_ready=0 at completion → result held, in_ready=0 until drained.
- Back-to-back add,sub,or with out_ready toggling 1,0,1 → no lost or duplicated results; PC 1,2,3 in order.
- rst_n low at mul cycle 8 → next cycle all outputs at reset values. opcode 100 → illegal=1, alu_result=0, PC+1.
